// File: rtl/instr_mem_responder_pkg.sv
// Purpose: shared types and constants for the instruction-fetch responder.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package instr_mem_responder_pkg;

   // Responder FSM states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // addi x0,x0,0 -- returned in place of data for bad fetches.
   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

   // Bits needed to index a word array of the given depth.
   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/instr_mem_responder_array.sv
// Purpose: DEPTH_WORDS x 32 instruction storage, one write port, one registered read port.
// Latency: read data valid the cycle after rd_en; a same-edge write to the read word is returned (write-first).
// Backpressure: none; rd_data holds its last value while rd_en is low.
// Ports: clk, rst_n (resets only the read register), wr_en/wr_idx/wr_data, rd_en/rd_idx, rd_data.
module imem_array
   import instr_mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int AW          = idx_width(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_idx,
   input  logic [31:0]   wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_idx,
   output logic [31:0]   rd_data
);

   logic [31:0] mem [DEPTH_WORDS];

   // Storage is intentionally not reset; boot code fills it through the write port.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   // Bypass the write data so a load landing on the read edge is seen immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= (wr_en && (wr_idx == rd_idx)) ? wr_data : mem[rd_idx];
      end
   end

endmodule

// File: rtl/instr_mem_responder.sv
// Purpose: instruction-fetch target; valid/ready request in, wait states, valid/ready instruction out, plus a load port.
// Latency: request accepted on edge N gives rsp_valid on edge N+1+WAIT_STATES; one fetch outstanding at a time.
// Backpressure: rsp_ready low holds the response stable; req_ready stays low until the response is consumed.
// Ports: clk, rst_n; req_valid/req_ready/req_addr; rsp_valid/rsp_ready/rsp_instr/rsp_err; load_en/load_addr/load_data.
module instr_mem_responder
   import instr_mem_responder_pkg::*;
#(
   parameter int          DEPTH_WORDS = 256,
   parameter int          WAIT_STATES = 1,
   parameter logic [31:0] NOP_INSTR   = NOP_INSTR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_instr,
   output logic        rsp_err,
   input  logic        load_en,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data
);

   localparam int          AW      = idx_width(DEPTH_WORDS);
   localparam logic [3:0]  WS_CNT  = 4'(WAIT_STATES);
   localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);

   state_e      state;
   logic [3:0]  wait_cnt;
   logic [31:0] addr_q;
   logic        rsp_err_q;
   logic [31:0] rd_data;
   logic        addr_ok;
   logic        load_ok;
   logic        enter_resp;
   logic        rd_en;
   logic        unused_load_lsb;

   assign addr_ok    = (addr_q[1:0] == 2'b00) && ({2'b00, addr_q[31:2]} < DEPTH_U);
   assign load_ok    = load_en && ({2'b00, load_addr[31:2]} < DEPTH_U);
   assign enter_resp = (state == ST_WAIT) && (wait_cnt == 4'd0);
   assign rd_en      = enter_resp && addr_ok;

   assign req_ready  = (state == ST_IDLE) && rst_n;
   assign rsp_err    = rsp_err_q;
   // Bad fetches return the NOP; good ones return the registered array word.
   assign rsp_instr  = rsp_err_q ? NOP_INSTR : rd_data;

   // Load address byte offset is don't-care.
   assign unused_load_lsb = ^load_addr[1:0];

   imem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (load_ok),
      .wr_idx  (load_addr[AW+1:2]),
      .wr_data (load_data),
      .rd_en   (rd_en),
      .rd_idx  (addr_q[AW+1:2]),
      .rd_data (rd_data)
   );

   // Every accept passes through WAIT (even with zero wait states) so the
   // array read is always driven from the latched address, one edge later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         wait_cnt  <= '0;
         addr_q    <= '0;
         rsp_valid <= 1'b0;
         rsp_err_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  addr_q   <= req_addr;
                  wait_cnt <= WS_CNT;
                  state    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (wait_cnt == 4'd0) begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err_q <= !addr_ok;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state     <= ST_IDLE;
                  rsp_valid <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_mem_responder.sv
module tb_instr_mem_responder;

   localparam int          DEPTH = 16;
   localparam int          AWT   = 4;
   localparam int          WS    = 1;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_instr;
   logic        rsp_err;
   logic        load_en = 1'b0;
   logic [31:0] load_addr = '0;
   logic [31:0] load_data = '0;

   logic        b_req_valid = 1'b0;
   logic        b_req_ready;
   logic [31:0] b_req_addr = '0;
   logic        b_rsp_valid;
   logic        b_rsp_ready = 1'b0;
   logic [31:0] b_rsp_instr;
   logic        b_rsp_err;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   instr_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_err(rsp_err),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
   );

   instr_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .NOP_INSTR(NOP)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_instr(b_rsp_instr), .rsp_err(b_rsp_err),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (time-stamp based) ----------------
   int          cyc = 0;
   logic        m_busy = 1'b0;
   int          m_acc = 0;
   logic [31:0] m_addr = '0;
   logic [31:0] m_instr = '0;
   logic        m_err = 1'b0;
   logic [31:0] m_mem [DEPTH];

   function automatic logic bad_addr(input logic [31:0] a);
      return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH));
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (load_en && !bad_addr({load_addr[31:2], 2'b00}))
         m_mem[load_addr[AWT+1:2]] <= load_data;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy  <= 1'b0;
         m_instr <= '0;
         m_err   <= 1'b0;
      end else if (!m_busy) begin
         if (req_valid) begin
            m_busy <= 1'b1;
            m_acc  <= cyc;
            m_addr <= req_addr;
         end
      end else if (cyc == m_acc + 1 + WS) begin
         m_err <= bad_addr(m_addr);
         if (bad_addr(m_addr))
            m_instr <= NOP;
         else if (load_en && (load_addr[31:2] == m_addr[31:2]))
            m_instr <= load_data;
         else
            m_instr <= m_mem[m_addr[AWT+1:2]];
      end else if ((cyc > m_acc + 1 + WS) && rsp_ready) begin
         m_busy <= 1'b0;
      end
   end

   logic exp_vld;
   logic exp_rdy;
   assign exp_vld = m_busy && (cyc > m_acc + 1 + WS);
   assign exp_rdy = rst_n && !m_busy;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("mdl_req_ready", 32'(req_ready), 32'(exp_rdy));
         chk("mdl_rsp_valid", 32'(rsp_valid), 32'(exp_vld));
         chk("mdl_rsp_instr", rsp_instr, m_instr);
         chk("mdl_rsp_err", 32'(rsp_err), 32'(m_err));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic fetch_a(input logic [31:0] addr, input logic [31:0] exp_i, input logic exp_e,
                          input string name);
      int lat;
      req_valid = 1'b1;
      req_addr  = addr;
      step();
      req_valid = 1'b0;
      req_addr  = $urandom;
      lat = 0;
      @(negedge clk);
      while (!rsp_valid && lat < 20) begin
         step();
         lat++;
         @(negedge clk);
      end
      chk({name, "_latency"}, 32'(lat), 32'(WS + 1));
      chk({name, "_instr"}, rsp_instr, exp_i);
      chk({name, "_err"}, 32'(rsp_err), 32'(exp_e));
      chk({name, "_busy_ready"}, 32'(req_ready), 32'd0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      @(negedge clk);
      chk({name, "_released_vld"}, 32'(rsp_valid), 32'd0);
      chk({name, "_released_rdy"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_instr", rsp_instr, 32'd0);
      chk("reset_rsp_err", 32'(rsp_err), 32'd0);
      chk("reset_req_ready", 32'(req_ready), 32'd0);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_req_ready", 32'(req_ready), 32'd1);
      chk_en = 1'b1;

      // Fill the array; word 0 gets the known instruction.
      step();
      for (int i = DEPTH - 1; i >= 0; i--) begin
         load_en   = 1'b1;
         load_addr = 32'(i * 4);
         load_data = (i == 0) ? 32'h0050_0093 : $urandom;
         step();
      end
      load_en = 1'b0;

      // Basic fetch with response held off for 5 cycles.
      req_valid = 1'b1;
      req_addr  = 32'h0;
      step();
      req_valid = 1'b0;
      @(negedge clk);
      chk("pc0_edge1_vld", 32'(rsp_valid), 32'd0);
      step();
      @(negedge clk);
      chk("pc0_edge2_vld", 32'(rsp_valid), 32'd0);
      step();
      @(negedge clk);
      chk("pc0_edge3_vld", 32'(rsp_valid), 32'd1);
      chk("pc0_instr", rsp_instr, 32'h0050_0093);
      chk("pc0_err", 32'(rsp_err), 32'd0);
      for (int i = 0; i < 5; i++) begin
         step();
         @(negedge clk);
         chk("hold_vld", 32'(rsp_valid), 32'd1);
         chk("hold_instr", rsp_instr, 32'h0050_0093);
         chk("hold_req_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("hold_release_vld", 32'(rsp_valid), 32'd0);
      chk("hold_release_rdy", 32'(req_ready), 32'd1);

      // Error fetches.
      step();
      fetch_a(32'h2, NOP, 1'b1, "misaligned");
      fetch_a(32'(4 * DEPTH), NOP, 1'b1, "out_of_range");
      fetch_a(32'h0, 32'h0050_0093, 1'b0, "after_err");

      // Load to the pending word during WAIT.
      req_valid = 1'b1;
      req_addr  = 32'h4;
      step();
      req_valid = 1'b0;
      load_en   = 1'b1;
      load_addr = 32'h4;
      load_data = 32'hDEAD_BEEF;
      step();
      load_en = 1'b0;
      step();
      @(negedge clk);
      chk("wait_load_vld", 32'(rsp_valid), 32'd1);
      chk("wait_load_instr", rsp_instr, 32'hDEAD_BEEF);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;

      // Load landing on the read edge (write-first), then a load while held.
      req_valid = 1'b1;
      req_addr  = 32'h4;
      step();
      req_valid = 1'b0;
      step();
      load_en   = 1'b1;
      load_addr = 32'h7;
      load_data = 32'hCAFE_F00D;
      step();
      load_en = 1'b0;
      @(negedge clk);
      chk("wfirst_vld", 32'(rsp_valid), 32'd1);
      chk("wfirst_instr", rsp_instr, 32'hCAFE_F00D);
      load_en   = 1'b1;
      load_addr = 32'h4;
      load_data = 32'h1111_1111;
      step();
      load_en = 1'b0;
      @(negedge clk);
      chk("resp_load_held_instr", rsp_instr, 32'hCAFE_F00D);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      fetch_a(32'h4, 32'h1111_1111, 1'b0, "resp_load_stored");

      // Out-of-range load must not alias onto word 0.
      load_en   = 1'b1;
      load_addr = 32'(4 * DEPTH);
      load_data = 32'h7777_7777;
      step();
      load_en = 1'b0;
      fetch_a(32'h0, 32'h0050_0093, 1'b0, "oor_load_ignored");

      // Reset during WAIT.
      req_valid = 1'b1;
      req_addr  = 32'h0;
      step();
      req_valid = 1'b0;
      rst_n     = 1'b0;
      @(negedge clk);
      chk("rst_wait_vld", 32'(rsp_valid), 32'd0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_wait_no_rsp", 32'(rsp_valid), 32'd0);
         chk("rst_wait_ready", 32'(req_ready), 32'd1);
         step();
      end
      fetch_a(32'h0, 32'h0050_0093, 1'b0, "array_kept");

      // Zero wait states: pcs 0,4,8 back to back on the second instance.
      b_rsp_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         b_req_valid = 1'b1;
         b_req_addr  = 32'(k * 4);
         step();
         b_req_valid = 1'b0;
         @(negedge clk);
         chk("ws0_accept_vld", 32'(b_rsp_valid), 32'd0);
         chk("ws0_accept_rdy", 32'(b_req_ready), 32'd0);
         step();
         @(negedge clk);
         chk("ws0_rsp_vld", 32'(b_rsp_valid), 32'd1);
         chk("ws0_rsp_instr", b_rsp_instr,
             (k == 0) ? 32'h0050_0093 : (k == 1) ? 32'h1111_1111 : m_mem[2]);
         chk("ws0_rsp_err", 32'(b_rsp_err), 32'd0);
         step();
         @(negedge clk);
         chk("ws0_done_vld", 32'(b_rsp_valid), 32'd0);
         chk("ws0_done_rdy", 32'(b_req_ready), 32'd1);
         step();
      end
      b_rsp_ready = 1'b0;

      // Randomized traffic checked by the model every cycle.
      for (int n = 0; n < 600; n++) begin
         int sel;
         rst_n     = ($urandom_range(0, 199) != 0);
         req_valid = $urandom_range(0, 1) == 1;
         rsp_ready = $urandom_range(0, 1) == 1;
         sel = $urandom_range(0, 9);
         if (sel <= 6)
            req_addr = 32'($urandom_range(0, DEPTH - 1) * 4);
         else if (sel == 7)
            req_addr = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
         else if (sel == 8)
            req_addr = 32'((DEPTH + $urandom_range(0, 7)) * 4);
         else
            req_addr = $urandom;
         load_en   = $urandom_range(0, 3) == 0;
         load_addr = 32'($urandom_range(0, DEPTH + 3) * 4 + $urandom_range(0, 3));
         load_data = $urandom;
         step();
      end
      rst_n     = 1'b1;
      req_valid = 1'b0;
      load_en   = 1'b0;
      rsp_ready = 1'b1;
      repeat (10) step();
      chk_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
